// File: rtl/if_id_buffer_pkg.sv
// if_id_buffer_pkg: shared constants and entry layout for the IF/ID fetch buffer
package if_id_buffer_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INCR = 32'd4;
  localparam int IFID_W = 64;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_entry_t;
endpackage

// File: rtl/if_id_buffer_storage.sv
// ifid_storage: DEPTH x 64 entry array; Clk, we/waddr/wdata write port, raddr/rdata async read port
module ifid_storage
  import if_id_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [IFID_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [IFID_W-1:0] rdata
);
  logic [IFID_W-1:0] mem [DEPTH];
  always_ff @(posedge Clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_buffer.sv
// if_id_buffer: FWFT fetch buffer; in_valid/in_pc/in_instr -> in_ready/pc_stall, flush, out_valid/out_ready/out_pc/out_pc_plus4/out_instr, count
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  output logic                       in_ready,
  output logic                       pc_stall,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_pc_plus4,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  ifid_entry_t head;
  assign in_ready = count < CW'(DEPTH);
  assign pc_stall = ~in_ready;
  assign out_valid = count != '0;
  assign push = in_valid & in_ready & ~flush;
  assign pop = out_valid & out_ready & ~flush;
  ifid_storage #(.DEPTH(DEPTH)) u_storage (
    .Clk(Clk),
    .we(push),
    .waddr(wr_ptr),
    .wdata({in_pc, in_instr}),
    .raddr(rd_ptr),
    .rdata(head)
  );
  always_ff @(posedge Clk) begin
    if (Reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= (push && !pop) ? count + CW'(1) : (pop && !push) ? count - CW'(1) : count;
    end
  end
  assign out_pc = out_valid ? head.pc : NOP_INSTR;
  assign out_pc_plus4 = out_valid ? head.pc + PC_INCR : NOP_INSTR;
  assign out_instr = out_valid ? head.instr : NOP_INSTR;
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: queue-model scoreboard bench for if_id_buffer with directed and random stimulus
module tb_if_id_buffer;
  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH+1);
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  logic Clk = 0;
  logic Reset, in_valid, flush, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, out_pc_plus4, out_instr;
  logic in_ready, pc_stall, out_valid;
  logic [CW-1:0] count;
  ent_t q[$];
  int checks = 0;
  int errors = 0;
  bit armed = 0;
  always #5 Clk = ~Clk;
  if_id_buffer #(.DEPTH(DEPTH)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .in_valid(in_valid),
    .in_pc(in_pc),
    .in_instr(in_instr),
    .in_ready(in_ready),
    .pc_stall(pc_stall),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4),
    .out_instr(out_instr),
    .count(count)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  always @(posedge Clk) begin
    bit acc;
    if (Reset) begin
      q.delete();
      armed = 1;
    end else if (flush) q.delete();
    else begin
      acc = in_valid && q.size() < DEPTH;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) q.push_back('{in_pc, in_instr});
    end
  end
  always @(negedge Clk) begin
    int n;
    if (armed) begin
      n = q.size();
      chk("count", 32'(count), n);
      chk("in_ready", 32'(in_ready), (n < DEPTH) ? 1 : 0);
      chk("pc_stall", 32'(pc_stall), (n >= DEPTH) ? 1 : 0);
      chk("out_valid", 32'(out_valid), (n != 0) ? 1 : 0);
      chk("out_pc", out_pc, n != 0 ? q[0].pc : 32'h0);
      chk("out_pc_plus4", out_pc_plus4, n != 0 ? q[0].pc + 32'd4 : 32'h0);
      chk("out_instr", out_instr, n != 0 ? q[0].instr : 32'h0);
    end
  end
  task automatic drive(input bit r, input bit v, input logic [31:0] pc, input logic [31:0] instr,
                       input bit ordy, input bit fl);
    Reset = r;
    in_valid = v;
    in_pc = pc;
    in_instr = instr;
    out_ready = ordy;
    flush = fl;
    @(posedge Clk);
    #1;
  endtask
  initial begin
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h0, 32'h2008_0005, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 1, 32'h0, 32'h11, 0, 0);
    drive(0, 1, 32'h4, 32'h22, 0, 0);
    drive(0, 1, 32'h8, 32'h33, 0, 0);
    drive(0, 1, 32'hC, 32'h44, 1, 0);
    drive(0, 1, 32'hC, 32'h44, 1, 0);
    drive(0, 1, 32'h10, 32'h55, 0, 0);
    drive(0, 1, 32'h14, 32'h66, 1, 1);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 32'hFFFF_FFFC, 32'h77, 0, 0);
    drive(0, 1, 32'h100, 32'h88, 0, 0);
    drive(1, 1, 32'h104, 32'h99, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
            ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom, $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
    drive(0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
